// File: rtl/fetch_pkg_vP.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the TRAP state).
package fetch_pkg_vP;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT,
    ST_HOLD,
    ST_TRAP
  } fetch_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT,
    ST_HOLD
  } fetch_state_t;
`endif

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_vp.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in
// flight to instruction memory and presents a registered instruction/PC/PC+4
// bundle to the IF/ID pipe register. Execute-stage redirects win over
// everything and discard any stale in-flight response via the drop flag.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets
// park the stage in TRAP and raise the sticky fetch_misaligned flag; without
// it the low two target bits are forced to zero).
module fetch_stage_vp
  import fetch_pkg_vP::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               sync_reset,
  input  logic               enabler,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] instruction_F,
  output logic [31:0]        PC_F,
  output logic [31:0]        PC_plus_4_F,
  output logic               valid_F,
  output logic               fetch_misaligned
);

  fetch_state_t       r_state,    w_state_nxt;
  logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]        r_req_pc,   w_req_pc_nxt;
  logic               r_drop,     w_drop_nxt;
  logic [INSTR_W-1:0] r_instr,    w_instr_nxt;
  logic [31:0]        r_pc,       w_pc_nxt;
  logic [31:0]        r_pc4,      w_pc4_nxt;
  logic               r_valid,    w_valid_nxt;

  logic [31:0]        w_target;
  logic               w_hs;
  logic               w_pending;
  logic               w_inflight_nxt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic               r_misaligned, w_misaligned_nxt;
  logic               w_target_misaligned;

  assign w_target            = redirect_target;
  assign w_target_misaligned = (redirect_target[1:0] != 2'b00);
  // A request is still in flight in WAIT, or in TRAP while a drain is pending.
  assign w_pending           = (r_state == ST_WAIT) || ((r_state == ST_TRAP) && r_drop);
  assign fetch_misaligned    = r_misaligned;
`else
  // Low bits are masked so a redirect can never produce a misaligned fetch.
  assign w_target         = redirect_target & 32'hFFFF_FFFC;
  assign w_pending        = (r_state == ST_WAIT);
  assign fetch_misaligned = 1'b0;
`endif

  assign imem_req_valid = (r_state == ST_REQUEST);
  assign imem_req_addr  = r_fetch_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;
  // True when a response will still be owed to us after this edge.
  assign w_inflight_nxt = w_hs || (w_pending && !imem_rsp_valid);

  assign instruction_F = r_instr;
  assign PC_F          = r_pc;
  assign PC_plus_4_F   = r_pc4;
  assign valid_F       = r_valid;

  // Next-state and next-datapath decode; redirect overrides every state.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    w_instr_nxt    = r_instr;
    w_pc_nxt       = r_pc;
    w_pc4_nxt      = r_pc4;
    w_valid_nxt    = r_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misaligned_nxt = r_misaligned;
`endif

    if (redirect) begin
      w_fetch_pc_nxt = w_target;
      w_valid_nxt    = 1'b0;
      // Anything still owed by memory belongs to the old path and is dropped.
      w_drop_nxt     = w_inflight_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_target_misaligned) begin
        w_state_nxt      = ST_TRAP;
        w_misaligned_nxt = 1'b1;
      end else begin
        w_state_nxt      = w_inflight_nxt ? ST_WAIT : ST_REQUEST;
        w_misaligned_nxt = 1'b0;
      end
`else
      w_state_nxt = w_inflight_nxt ? ST_WAIT : ST_REQUEST;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_REQUEST;
        end
        ST_REQUEST: begin
          if (w_hs) begin
            w_req_pc_nxt = r_fetch_pc;
            w_state_nxt  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = ST_REQUEST;
            end else begin
              w_instr_nxt    = imem_rsp_data;
              w_pc_nxt       = r_req_pc;
              w_pc4_nxt      = pc_inc(r_req_pc);
              w_valid_nxt    = 1'b1;
              w_fetch_pc_nxt = pc_inc(r_req_pc);
              w_state_nxt    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (enabler) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_REQUEST;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_TRAP: begin
          if (r_drop && imem_rsp_valid) begin
            w_drop_nxt = 1'b0;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC tracking and the registered IF/ID bundle.
  always_ff @(posedge clock) begin
    if (!sync_reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_drop     <= 1'b0;
      r_instr    <= '0;
      r_pc       <= 32'h0;
      r_pc4      <= 32'h0;
      r_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_instr    <= w_instr_nxt;
      r_pc       <= w_pc_nxt;
      r_pc4      <= w_pc4_nxt;
      r_valid    <= w_valid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= w_misaligned_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage_vp.sv
// Directed bench for fetch_stage_vp with a small instruction-memory responder
// whose response latency is set per scenario.
module tb_fetch_stage_vp;

  logic        clock = 1'b0;
  logic        sync_reset;
  logic        enabler;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction_F;
  logic [31:0] PC_F;
  logic [31:0] PC_plus_4_F;
  logic        valid_F;
  logic        fetch_misaligned;

  int total = 0;
  int bad   = 0;

  fetch_stage_vp #(.RESET_PC(32'h0000_0000)) dut (
    .clock           (clock),
    .sync_reset      (sync_reset),
    .enabler         (enabler),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instruction_F   (instruction_F),
    .PC_F            (PC_F),
    .PC_plus_4_F     (PC_plus_4_F),
    .valid_F         (valid_F),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clock = ~clock;

  // Memory image: address 0 holds the test instruction, 0xC holds a marker
  // word that must never reach the bundle when its fetch is redirected away.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h003100F8;
    if (a == 32'hC) return 32'hDEADBEEF;
    return {a[23:0], 8'h13};
  endfunction

  // Single-outstanding responder; lat = cycles from accept edge to consume edge.
  logic        pend  = 1'b0;
  int          cnt   = 0;
  logic [31:0] paddr = 32'h0;
  int          lat   = 1;
  int          hs_count = 0;
  logic [31:0] last_hs_addr = 32'h0;
  int          viol  = 0;

  assign imem_rsp_valid = pend && (cnt == 0);
  assign imem_rsp_data  = mem_word(paddr);

  always @(posedge clock) begin
    if (imem_rsp_valid) pend <= 1'b0;
    else if (pend && cnt != 0) cnt <= cnt - 1;
    if (imem_req_valid && imem_req_ready) begin
      if (pend && !imem_rsp_valid) viol <= viol + 1;
      pend         <= 1'b1;
      cnt          <= lat - 1;
      paddr        <= imem_req_addr;
      hs_count     <= hs_count + 1;
      last_hs_addr <= imem_req_addr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    sync_reset = 1'b0; enabler = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; imem_req_ready = 1'b1; lat = 1;
    repeat (2) tick();
    total++; if (valid_F !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_F); end
    total++; if (instruction_F !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instruction_F); end
    total++; if (PC_F !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", PC_F); end
    total++; if (PC_plus_4_F !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 0", PC_plus_4_F); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misal: got %b want 0", fetch_misaligned); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_reqv: got %b want 0", imem_req_valid); end
    sync_reset = 1'b1;
  endtask

  task automatic test_first_fetch();
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (valid_F !== 1'b0) begin bad++; $display("FAIL first_early_valid: got %b want 0", valid_F); end
    tick();
    total++; if (valid_F !== 1'b1 || instruction_F !== 32'h003100F8) begin bad++; $display("FAIL first_bundle: got v=%b i=%h want v=1 i=003100f8", valid_F, instruction_F); end
    total++; if (PC_F !== 32'h0 || PC_plus_4_F !== 32'h4) begin bad++; $display("FAIL first_pc: got pc=%h pc4=%h want 0/4", PC_F, PC_plus_4_F); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instruction_F !== 32'h003100F8 || PC_F !== 32'h0 || valid_F !== 1'b1 || imem_req_valid !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d]: got i=%h pc=%h v=%b rq=%b want 003100f8/0/1/0", i, instruction_F, PC_F, valid_F, imem_req_valid);
      end
    end
    enabler = 1'b1; tick(); enabler = 1'b0;
    total++; if (valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL stall_release: got v=%b rq=%b a=%h want 0/1/4", valid_F, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_ready_low();
    int h0;
    tick(); tick();
    total++; if (PC_F !== 32'h4 || instruction_F !== 32'h0000_0413) begin bad++; $display("FAIL pc4_fetch: got pc=%h i=%h want 4/00000413", PC_F, instruction_F); end
    imem_req_ready = 1'b0;
    enabler = 1'b1; tick(); enabler = 1'b0;
    h0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL rdy_low_addr[%0d]: got v=%b a=%h want 1/8", i, imem_req_valid, imem_req_addr); end
      if (i < 2) tick();
    end
    imem_req_ready = 1'b1;
    tick();
    total++; if (hs_count !== h0 + 1 || last_hs_addr !== 32'h8) begin bad++; $display("FAIL rdy_hs: got n=%0d a=%h want %0d/8", hs_count, last_hs_addr, h0 + 1); end
    tick();
    total++; if (PC_F !== 32'h8 || instruction_F !== 32'h0000_0813 || valid_F !== 1'b1) begin bad++; $display("FAIL rdy_bundle: got pc=%h i=%h v=%b want 8/00000813/1", PC_F, instruction_F, valid_F); end
    tick();
    total++; if (hs_count !== h0 + 1) begin bad++; $display("FAIL rdy_no_dup: got %0d want %0d", hs_count, h0 + 1); end
    enabler = 1'b1; tick(); enabler = 1'b0;
  endtask

  task automatic test_stale_response();
    logic saw_stale;
    saw_stale = 1'b0;
    lat = 3;
    tick();
    total++; if (last_hs_addr !== 32'hC) begin bad++; $display("FAIL stale_req: got %h want c", last_hs_addr); end
    lat = 1;
    redirect = 1'b1; redirect_target = 32'h100;
    tick();
    redirect = 1'b0;
    total++; if (valid_F !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL stale_redir: got v=%b rq=%b want 0/0", valid_F, imem_req_valid); end
    for (int i = 0; i < 12 && valid_F !== 1'b1; i++) begin
      tick();
      if (valid_F === 1'b1 && instruction_F === 32'hDEADBEEF) saw_stale = 1'b1;
    end
    total++; if (saw_stale !== 1'b0) begin bad++; $display("FAIL stale_leak: got %b want 0", saw_stale); end
    total++; if (valid_F !== 1'b1 || PC_F !== 32'h100 || instruction_F !== 32'h0001_0013) begin bad++; $display("FAIL stale_target: got v=%b pc=%h i=%h want 1/100/00010013", valid_F, PC_F, instruction_F); end
  endtask

  task automatic test_redirect_with_rsp();
    enabler = 1'b1; tick(); enabler = 1'b0;
    tick();
    total++; if (imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL same_rsp_setup: got %b want 1", imem_rsp_valid); end
    redirect = 1'b1; redirect_target = 32'h180;
    tick();
    redirect = 1'b0;
    total++; if (valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h180) begin bad++; $display("FAIL same_redir: got v=%b rq=%b a=%h want 0/1/180", valid_F, imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (PC_F !== 32'h180 || PC_plus_4_F !== 32'h184 || instruction_F !== 32'h0001_8013 || valid_F !== 1'b1) begin bad++; $display("FAIL same_bundle: got pc=%h pc4=%h i=%h v=%b want 180/184/00018013/1", PC_F, PC_plus_4_F, instruction_F, valid_F); end
  endtask

  task automatic test_redirect_hold();
    redirect = 1'b1; redirect_target = 32'h240;
    tick();
    redirect = 1'b0;
    total++; if (valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h240) begin bad++; $display("FAIL hold_redir: got v=%b rq=%b a=%h want 0/1/240", valid_F, imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (PC_F !== 32'h240 || instruction_F !== 32'h0002_4013) begin bad++; $display("FAIL hold_bundle: got pc=%h i=%h want 240/00024013", PC_F, instruction_F); end
  endtask

  task automatic test_misaligned();
    int h0;
    redirect = 1'b1; redirect_target = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL misal_trap: got f=%b rq=%b want 1/0", fetch_misaligned, imem_req_valid); end
    h0 = hs_count;
    repeat (3) tick();
    total++; if (hs_count !== h0 || fetch_misaligned !== 1'b1 || valid_F !== 1'b0) begin bad++; $display("FAIL misal_sticky: got n=%0d f=%b v=%b want %0d/1/0", hs_count, fetch_misaligned, valid_F, h0); end
    redirect = 1'b1; redirect_target = 32'h200;
    tick();
    redirect = 1'b0;
    total++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL misal_exit: got f=%b rq=%b a=%h want 0/1/200", fetch_misaligned, imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (PC_F !== 32'h200 || instruction_F !== 32'h0002_0013) begin bad++; $display("FAIL misal_bundle: got pc=%h i=%h want 200/00020013", PC_F, instruction_F); end
`else
    h0 = hs_count;
    total++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL misal_mask: got f=%b rq=%b a=%h want 0/1/100", fetch_misaligned, imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (PC_F !== 32'h100 || hs_count !== h0 + 1) begin bad++; $display("FAIL misal_bundle: got pc=%h n=%0d want 100/%0d", PC_F, hs_count, h0 + 1); end
`endif
  endtask

  task automatic test_pc_wrap();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick(); tick();
    total++; if (PC_F !== 32'hFFFF_FFFC || PC_plus_4_F !== 32'h0 || instruction_F !== 32'hFFFF_FC13) begin bad++; $display("FAIL wrap_bundle: got pc=%h pc4=%h i=%h want fffffffc/0/fffffc13", PC_F, PC_plus_4_F, instruction_F); end
    enabler = 1'b1; tick(); enabler = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got rq=%b a=%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_midflight();
    lat = 2;
    tick();
    sync_reset = 1'b0;
    tick();
    sync_reset = 1'b1;
    lat = 1;
    total++; if (valid_F !== 1'b0 || PC_F !== 32'h0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_state: got v=%b pc=%h rq=%b want 0/0/0", valid_F, PC_F, imem_req_valid); end
    total++; if (imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL midrst_rsp_setup: got %b want 1", imem_rsp_valid); end
    tick();
    total++; if (valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL midrst_ignore: got v=%b rq=%b a=%h want 0/1/0", valid_F, imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (valid_F !== 1'b1 || PC_F !== 32'h0 || instruction_F !== 32'h003100F8) begin bad++; $display("FAIL midrst_bundle: got v=%b pc=%h i=%h want 1/0/003100f8", valid_F, PC_F, instruction_F); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    nvalid = 0;
    enabler = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (valid_F === 1'b1) nvalid++;
    end
    enabler = 1'b0;
    total++; if (nvalid !== 3) begin bad++; $display("FAIL b2b_rate: got %0d want 3", nvalid); end
    total++; if (PC_F !== 32'hC || valid_F !== 1'b1) begin bad++; $display("FAIL b2b_pc: got pc=%h v=%b want c/1", PC_F, valid_F); end
  endtask

  task automatic test_single_outstanding();
    total++; if (viol !== 0) begin bad++; $display("FAIL outstanding: got %0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_ready_low();
    test_stale_response();
    test_redirect_with_rsp();
    test_redirect_hold();
    test_misaligned();
    test_pc_wrap();
    test_reset_midflight();
    test_back_to_back();
    test_single_outstanding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage_vp.md
# fetch_stage_vP

Instruction-fetch stage of the pipelined RV32I core. Owns the fetch PC, issues one request at a time to instruction memory over a valid/ready interface, and presents a registered instruction/PC/PC+4 bundle to the IF/ID pipe register. Handles decode stalls and execute-stage redirects (branch/jump). Redirects discard stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clock  in  1  rising-edge clock
- sync_reset  in  1  synchronous, active-low reset
- enabler  in  1  IF/ID pipe accepts this cycle (0 = stall)
- redirect  in  1  taken branch/jump from execute (PCSrc_E)
- redirect_target  in  32  new fetch PC (PC_target_E)
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, sampled only on handshake
- imem_rsp_valid  in  1  response valid (≥1 cycle after accept)
- imem_rsp_data  in  32  instruction word
- instruction_F  out  32  fetched instruction to IF/ID
- PC_F  out  32  PC of instruction_F
- PC_plus_4_F  out  32  PC_F + 4
- valid_F  out  1  bundle valid
- fetch_misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Registers: state, fetch_pc, req_pc, drop, output bundle.
- States: IDLE, REQUEST, WAIT, HOLD, TRAP (TRAP only with macro).
- IDLE: req_valid=0; → REQUEST next cycle.
- REQUEST: req_valid=1, req_addr=fetch_pc. Handshake (valid&ready): req_pc<=fetch_pc, → WAIT.
- WAIT: on rsp_valid: if drop → discard, drop<=0, → REQUEST; else load instruction_F=rsp_data, PC_F=req_pc, PC_plus_4_F=req_pc+4, valid_F<=1, fetch_pc<=req_pc+4, → HOLD.
- HOLD: bundle held stable while enabler=0; enabler=1 → bundle consumed at that edge, valid_F<=0, → REQUEST.
- Redirect has priority over all of the above in every state, regardless of enabler:
  - fetch_pc<=redirect_target, valid_F<=0.
  - IDLE/HOLD/REQUEST without handshake → REQUEST (no drop); req_addr may change while un-accepted.
  - REQUEST with simultaneous handshake → WAIT, drop<=1.
  - WAIT without rsp_valid → stay WAIT, drop<=1.
  - WAIT with simultaneous rsp_valid → response discarded, → REQUEST, drop<=0.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- At most one outstanding request; memory never returns unrequested responses.

## Timing
- Reset (sync_reset=0 at edge): state=IDLE, fetch_pc=RESET_PC, req_pc=0, drop=0, instruction_F=0, PC_F=0, PC_plus_4_F=0, valid_F=0, fetch_misaligned=0. imem_req_valid=0 while in IDLE.
- Reset mid-operation: in-flight response arriving in IDLE/REQUEST is ignored.
- Zero-wait memory (ready=1, response next cycle): REQUEST→WAIT→HOLD; valid_F high 2 cycles after request cycle; peak throughput 1 instruction / 3 cycles.
- Redirect at edge N: valid_F=0 from N; first request to target at N+1 (or after stale response drains).
- imem_req_valid, imem_req_addr decoded from state/fetch_pc; outputs to IF/ID fully registered.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_target[1:0]≠0 → TRAP; fetch_misaligned<=1 (sticky); no requests issued; outstanding response still drained and discarded via drop. Leave TRAP only by aligned redirect (→ REQUEST, flag cleared) or reset.
- Undefined: redirect_target[1:0] forced to 2'b00; fetch_misaligned tied 0; no TRAP state.

## Structure
- Package fetch_pkg_vP: fetch_state_t enum, RESET_PC_DEFAULT, INSTR_W=32.
- No sub-module; PC+4 adder and output register inline.

## Test plan
- Reset release, RESET_PC=0, ready=1, 1-cycle memory returning 32'h003100F8 → req_addr=0 in first REQUEST; valid_F=1, instruction_F=32'h003100F8, PC_F=0, PC_plus_4_F=4.
- enabler=0 for 5 cycles while HOLD → bundle unchanged, imem_req_valid=0; enabler=1 → next req_addr=4.
- imem_req_ready low 3 cycles → req_addr stable at 8, single handshake, no duplicate fetch.
- Redirect to 32'h100 in WAIT, stale response 32'hDEADBEEF arrives later → never on instruction_F; next valid_F shows PC_F=32'h100.
- Redirect and rsp_valid in same cycle; redirect in HOLD with enabler=0 → valid_F=0 next cycle, next req_addr=target.
- Macro defined: redirect to 32'h102 → fetch_misaligned=1, no requests; redirect to 32'h200 → flag cleared, req_addr=32'h200. Macro undefined: same stimulus → req_addr=32'h100.
